// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: arms, runs and terminates a serial bit-pattern search.
// A start command in IDLE latches the pattern, required match count and bit
// timeout. SCAN shifts qualified bits through a history register and raises a
// combinational Mealy match pulse on the cycle of the final pattern bit
// (overlapping matches allowed). DONE lasts one cycle and pulses done.
//
// Optional feature macro: PATTERN_SCAN_ABORT_EN
//   Adds input abort / output aborted. abort in SCAN ends the scan on the next
//   cycle, the same-cycle bit is not accepted and aborted is set.
//
// Handshake: start is a single-cycle command sampled on the rising edge and is
// accepted only while in IDLE; a_valid qualifies a, and each cycle with
// a_valid=1 in SCAN consumes exactly one bit (there is no back-pressure).
module pattern_scan_ctrl #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8,
   parameter int TMO_W = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] target,
   input  logic [TMO_W-1:0] timeout,
   input  logic             a_valid,
   input  logic             a,
`ifdef PATTERN_SCAN_ABORT_EN
   input  logic             abort,
   output logic             aborted,
`endif
   output logic             busy,
   output logic             match,
   output logic             done,
   output logic             timed_out,
   output logic [CNT_W-1:0] match_cnt,
   output logic [1:0]       state_dbg
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SCAN = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam int              FILL_W   = $clog2(PAT_W);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

   logic [1:0]       state_q,     state_d;
   logic [PAT_W-1:0] pattern_q,   pattern_d;
   logic [CNT_W-1:0] target_q,    target_d;
   logic [TMO_W-1:0] timeout_q,   timeout_d;
   logic [PAT_W-2:0] hist_q,      hist_d;
   logic [FILL_W-1:0] fill_q,     fill_d;
   logic [TMO_W-1:0] bit_cnt_q,   bit_cnt_d;
   logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
   logic             timed_out_q, timed_out_d;
`ifdef PATTERN_SCAN_ABORT_EN
   logic             aborted_q,   aborted_d;
`endif

   logic             in_scan;
   logic             abort_req;
   logic             accept;
   logic [PAT_W-1:0] window;
   logic             match_hit;
   logic [CNT_W-1:0] cnt_inc;
   logic [TMO_W-1:0] bit_inc;
   logic             tgt_hit;
   logic             tmo_hit;

   assign in_scan = (state_q == S_SCAN);

`ifdef PATTERN_SCAN_ABORT_EN
   assign abort_req = in_scan & abort;
`else
   assign abort_req = 1'b0;
`endif

   // A bit is consumed only in SCAN, when qualified, and when not being aborted.
   assign accept    = in_scan & a_valid & ~abort_req;
   // The newest bit joins the stored history to form the candidate window;
   // the low PAT_W-1 bits of the window become the next history.
   assign window    = {hist_q, a};
   assign match_hit = accept & (fill_q == FILL_MAX) & (window == pattern_q);
   assign cnt_inc   = match_cnt_q + CNT_W'(1);
   assign bit_inc   = bit_cnt_q + TMO_W'(1);
   assign tgt_hit   = match_hit & (cnt_inc == target_q);
   assign tmo_hit   = accept & (timeout_q != '0) & (bit_inc == timeout_q);

   // Next-state logic for the sequencer, the matcher history and the counters.
   always_comb begin
      state_d     = state_q;
      pattern_d   = pattern_q;
      target_d    = target_q;
      timeout_d   = timeout_q;
      hist_d      = hist_q;
      fill_d      = fill_q;
      bit_cnt_d   = bit_cnt_q;
      match_cnt_d = match_cnt_q;
      timed_out_d = timed_out_q;
`ifdef PATTERN_SCAN_ABORT_EN
      aborted_d   = aborted_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               pattern_d   = pattern;
               target_d    = target;
               timeout_d   = timeout;
               hist_d      = '0;
               fill_d      = '0;
               bit_cnt_d   = '0;
               match_cnt_d = '0;
               timed_out_d = 1'b0;
`ifdef PATTERN_SCAN_ABORT_EN
               aborted_d   = 1'b0;
`endif
               // A zero target is already satisfied: skip scanning entirely.
               state_d = (target == '0) ? S_DONE : S_SCAN;
            end
         end
         S_SCAN: begin
            if (abort_req) begin
               state_d = S_DONE;
`ifdef PATTERN_SCAN_ABORT_EN
               aborted_d = 1'b1;
`endif
            end else if (accept) begin
               hist_d    = window[PAT_W-2:0];
               bit_cnt_d = bit_inc;
               if (fill_q != FILL_MAX) begin
                  fill_d = fill_q + FILL_W'(1);
               end
               if (match_hit) begin
                  match_cnt_d = cnt_inc;
               end
               // Reaching the target on the timeout bit counts as success.
               if (tgt_hit) begin
                  state_d = S_DONE;
               end else if (tmo_hit) begin
                  state_d     = S_DONE;
                  timed_out_d = 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         pattern_q   <= '0;
         target_q    <= '0;
         timeout_q   <= '0;
         hist_q      <= '0;
         fill_q      <= '0;
         bit_cnt_q   <= '0;
         match_cnt_q <= '0;
         timed_out_q <= 1'b0;
`ifdef PATTERN_SCAN_ABORT_EN
         aborted_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         pattern_q   <= pattern_d;
         target_q    <= target_d;
         timeout_q   <= timeout_d;
         hist_q      <= hist_d;
         fill_q      <= fill_d;
         bit_cnt_q   <= bit_cnt_d;
         match_cnt_q <= match_cnt_d;
         timed_out_q <= timed_out_d;
`ifdef PATTERN_SCAN_ABORT_EN
         aborted_q   <= aborted_d;
`endif
      end
   end

   assign busy      = (state_q == S_SCAN) | (state_q == S_DONE);
   assign done      = (state_q == S_DONE);
   assign match     = match_hit;
   assign timed_out = timed_out_q;
   assign match_cnt = match_cnt_q;
   assign state_dbg = state_q;
`ifdef PATTERN_SCAN_ABORT_EN
   assign aborted   = aborted_q;
`endif

endmodule
